// File: rtl/prog_boot_pkg.sv
`default_nettype none
// =============================================================================
// Module      : prog_boot_pkg
// Description : Shared types and constants for the boot-time program loader.
// Revision    : 1.0 - initial release
// =============================================================================
package prog_boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } prog_boot_state_e;

    localparam int         HDR_BYTES  = 8;
    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BE_ALL     = 4'hF;

endpackage
`default_nettype wire

// File: rtl/prog_boot_asm.sv
`default_nettype none
// =============================================================================
// Module      : prog_boot_asm
// Description : Little-endian byte-to-word assembler; pulses word_valid_o on
//               the 4th accepted byte with the complete word on word_o.
// Revision    : 1.0 - initial release
// =============================================================================
module prog_boot_asm (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clr_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = {byte_i, shift_q[23:8]};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // The 4th byte is forwarded combinationally so the FSM can act on it this cycle.
    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = byte_valid_i & (idx_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/prog_boot_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : prog_boot_ctrl
// Description : Loads a framed UART byte image into instruction memory, then
//               releases core reset. Define PROG_BOOT_CSUM_EN to require an
//               8-bit checksum trailer byte after the data.
// Revision    : 1.0 - initial release
// =============================================================================
module prog_boot_ctrl
    import prog_boot_pkg::*;
#(
    parameter int AW        = 32,
    parameter int MAX_WORDS = 4096
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    output logic          rx_ready_o,
    output logic          mem_req_o,
    input  logic          mem_gnt_i,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [3:0]    mem_be_o,
    output logic          core_rst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int          RW    = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

`ifdef PROG_BOOT_CSUM_EN
    localparam prog_boot_state_e S_TAIL = S_CSUM;
`else
    localparam prog_boot_state_e S_TAIL = S_DONE;
`endif

    prog_boot_state_e state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [RW-1:0]    remain_q, remain_d;
    logic             err_q, done_q, core_rst_q;

    logic             w_rx_ready, w_rx_fire, w_clr, w_word_valid;
    logic [31:0]      w_word;

    assign w_rx_ready = (state_q == S_ADDR) || (state_q == S_LEN) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign w_rx_fire  = rx_valid_i & w_rx_ready;
    assign w_clr      = (state_d != state_q);

    prog_boot_asm u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (w_clr),
        .byte_valid_i (w_rx_fire),
        .byte_i       (rx_data_i),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

`ifdef PROG_BOOT_CSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (((state_q == S_IDLE) || (state_q == S_ERR)) && start_i) begin
            sum_d = '0;
        end else if ((state_q == S_DATA) && w_rx_fire) begin
            sum_d = sum_q + rx_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        remain_d = remain_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_ADDR;
            S_ADDR: begin
                if (w_word_valid) begin
                    if (w_word[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = AW'(w_word);
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (w_word_valid) begin
                    if (w_word > MAX_W) begin
                        state_d = S_ERR;
                    end else if (w_word == 32'd0) begin
                        state_d = S_TAIL;
                    end else begin
                        remain_d = RW'(w_word);
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_valid) begin
                    wdata_d = w_word;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_gnt_i) begin
                    addr_d   = addr_q + AW'(WORD_BYTES);
                    remain_d = remain_q - RW'(1);
                    state_d  = (remain_q == RW'(1)) ? S_TAIL : S_DATA;
                end
            end
            S_CSUM: begin
`ifdef PROG_BOOT_CSUM_EN
                if (w_rx_fire) begin
                    state_d = ((sum_q + rx_data_i) == 8'h00) ? S_DONE : S_ERR;
                end
`else
                state_d = S_ERR;
`endif
            end
            S_DONE: state_d = S_DONE;
            S_ERR:  if (start_i) state_d = S_ADDR;
            default: state_d = S_IDLE;
        endcase
    end

    // done/core_rst lag DONE entry by one cycle; DONE is terminal so both stay sticky.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            remain_q   <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            remain_q   <= remain_d;
            err_q      <= (state_d == S_ERR);
            done_q     <= (state_q == S_DONE);
            core_rst_q <= (state_q != S_DONE);
        end
    end

    assign rx_ready_o  = w_rx_ready;
    assign mem_req_o   = (state_q == S_WRITE);
    assign mem_we_o    = mem_req_o;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = BE_ALL;
    assign core_rst_o  = core_rst_q;
    assign busy_o      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire
